// File: rtl/la_regbank_pkg.sv
// Shared constants for the logic-analyser register bank: opcodes, FSM states, status bit layout,
// and the opcode legality table.
package la_regbank_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StProc = 2'd2,
    StRead = 2'd3
  } state_e;

  localparam logic [3:0] OpLoad   = 4'h1;
  localparam logic [3:0] OpWrite  = 4'h2;
  localparam logic [3:0] OpGo     = 4'h3;
  localparam logic [3:0] OpRead   = 4'h4;
  localparam logic [3:0] OpFinish = 4'h5;
  localparam logic [3:0] OpAbort  = 4'hF;

  // Bit positions within la_data_out[31:0]
  localparam int unsigned StatStateLsb = 30;
  localparam int unsigned StatToggle   = 29;
  localparam int unsigned StatErrCmd   = 28;
  localparam int unsigned StatErrTo    = 27;
  localparam int unsigned StatCntLsb   = 16;

  function automatic logic op_legal(state_e st, logic [3:0] op);
    case (op)
      OpLoad:           return st == StIdle;
      OpWrite, OpGo:    return st == StLoad;
      OpRead, OpFinish: return st == StRead;
      OpAbort:          return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/la_proc_timer.sv
// Watchdog counter for the PROC state; expired is high on the LIMIT-th enabled cycle.
module la_proc_timer #(
  parameter int unsigned LIMIT = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  assign expired = enable && (cnt_q == CntW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/la_regbank_ctrl.sv
// Toggle-handshaked command controller that loads, hands off and reads back a bank of wide
// operand registers over the LA bus. Define LA_REGBANK_TIMEOUT_EN to add the PROC watchdog.
module la_regbank_ctrl
  import la_regbank_pkg::*;
#(
  parameter int unsigned REG_W    = 163,
  parameter int unsigned NUM_REGS = 7,
  parameter int unsigned CHUNK_W  = 82,
  parameter int unsigned TIMEOUT  = 2000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic [127:0]              la_data_in,
  input  logic [127:0]              la_oenb,
  output logic [127:0]              la_data_out,
  output logic [NUM_REGS*REG_W-1:0] regs_o,
  output logic                      core_start_o,
  input  logic                      core_done_i,
  input  logic                      core_wr_en_i,
  input  logic [3:0]                core_wr_idx_i,
  input  logic [REG_W-1:0]          core_wr_data_i
);

  localparam int unsigned NCH    = (REG_W + CHUNK_W - 1) / CHUNK_W;
  localparam int unsigned WIDE_W = NCH * CHUNK_W;

  // Release is delayed two edges so no state flop leaves reset on a marginal edge
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_sync_q <= '0;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic             tog;
  logic [3:0]       opcode, cmd_reg, cmd_chunk;
  state_e           state_q, state_d;
  logic             toggle_q, echo_q, start_q, start_d, err_cmd_q, err_to_q;
  logic [7:0]       cnt_q;
  logic [95:0]      rdata_q;
  logic [REG_W-1:0] regs_q [NUM_REGS];
  logic [REG_W-1:0] regs_d [NUM_REGS];
  logic [REG_W-1:0] sel_reg;
  logic [CHUNK_W-1:0] rd_chunk;
  logic [WIDE_W-1:0]  chunk_mask, chunk_data;
  logic [31:0]      shift, status;
  logic             in_proc, expired, done_evt, exec, idx_ok, accept, reject, timeout_hit;

  assign opcode    = la_data_in[31:28] & ~la_oenb[31:28];
  assign cmd_reg   = la_data_in[27:24] & ~la_oenb[27:24];
  assign cmd_chunk = la_data_in[23:20] & ~la_oenb[23:20];
  assign tog       = la_data_in[15] & ~la_oenb[15];

  assign in_proc = (state_q == StProc);

`ifdef LA_REGBANK_TIMEOUT_EN
  la_proc_timer #(
    .LIMIT(TIMEOUT)
  ) u_proc_timer (
    .clk    (wb_clk_i),
    .rst_n  (rst_n),
    .enable (in_proc),
    .clear  (!in_proc),
    .expired(expired)
  );
  logic unused_inputs;
  assign unused_inputs = ^{la_oenb, la_data_in};
`else
  assign expired = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{la_oenb, la_data_in, 32'(TIMEOUT)};
`endif

  // Completion wins over a same-cycle toggle; the command stays pending for the next cycle
  assign done_evt    = in_proc && (core_done_i || expired);
  assign timeout_hit = in_proc && expired && !core_done_i;
  assign exec        = (tog != toggle_q) && !done_evt;
  assign idx_ok      = (32'(cmd_reg) < NUM_REGS) && (32'(cmd_chunk) < NCH);
  assign accept      = exec && idx_ok && op_legal(state_q, opcode);
  assign reject      = exec && !accept;

  assign shift      = 32'(cmd_chunk) * CHUNK_W;
  assign chunk_mask = WIDE_W'({CHUNK_W{1'b1}}) << shift;
  assign chunk_data = WIDE_W'(la_data_in[32 +: CHUNK_W]) << shift;

  always_comb begin
    sel_reg = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cmd_reg == 4'(k)) sel_reg = regs_q[k];
    end
  end
  assign rd_chunk = CHUNK_W'(WIDE_W'(sel_reg) >> shift);

  always_comb begin
    regs_d = regs_q;
    if (accept && opcode == OpLoad) begin
      for (int k = 0; k < NUM_REGS; k++) regs_d[k] = '0;
    end else if (accept && opcode == OpWrite) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (cmd_reg == 4'(k)) begin
          regs_d[k] = REG_W'((WIDE_W'(regs_q[k]) & ~chunk_mask) | chunk_data);
        end
      end
    end
    if (in_proc && core_wr_en_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (core_wr_idx_i == 4'(k)) regs_d[k] = core_wr_data_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    if (done_evt) begin
      state_d = StRead;
    end else if (accept) begin
      case (opcode)
        OpLoad:            state_d = StLoad;
        OpGo: begin
          state_d = StProc;
          start_d = 1'b1;
        end
        OpFinish, OpAbort: state_d = StIdle;
        default:           state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      toggle_q  <= 1'b0;
      echo_q    <= 1'b0;
      cnt_q     <= '0;
      err_cmd_q <= 1'b0;
      err_to_q  <= 1'b0;
      rdata_q   <= '0;
      regs_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      regs_q  <= regs_d;
      if (!done_evt) toggle_q <= tog;
      if (exec) begin
        echo_q <= tog;
        cnt_q  <= cnt_q + 8'd1;
      end
      if (accept && opcode == OpRead) rdata_q <= 96'(rd_chunk);
      if (accept && opcode == OpLoad) begin
        err_cmd_q <= 1'b0;
        err_to_q  <= 1'b0;
      end else begin
        if (reject)      err_cmd_q <= 1'b1;
        if (timeout_hit) err_to_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    status                     = '0;
    status[StatStateLsb +: 2]  = state_q;
    status[StatToggle]         = echo_q;
    status[StatErrCmd]         = err_cmd_q;
    status[StatErrTo]          = err_to_q;
    status[StatCntLsb +: 8]    = cnt_q;
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_o[k*REG_W +: REG_W] = regs_q[k];
  end

  assign la_data_out  = {rdata_q, status};
  assign core_start_o = start_q;

endmodule

// File: tb/tb_la_regbank_ctrl.sv
// Directed self-checking bench for la_regbank_ctrl; build with LA_REGBANK_TIMEOUT_EN to exercise
// the watchdog path.
module tb_la_regbank_ctrl;

  localparam int unsigned REG_W    = 163;
  localparam int unsigned NUM_REGS = 7;
  localparam int unsigned CHUNK_W  = 82;
  localparam int unsigned TIMEOUT  = 20;
`ifdef LA_REGBANK_TIMEOUT_EN
  localparam int DONE_CYC = 10;
`else
  localparam int DONE_CYC = 50;
`endif

  localparam logic [3:0] OP_LOAD = 4'h1, OP_WRITE = 4'h2, OP_GO = 4'h3, OP_READ = 4'h4;
  localparam logic [3:0] OP_FINISH = 4'h5, OP_ABORT = 4'hF;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [127:0]              la_data_in;
  logic [127:0]              la_oenb;
  logic [127:0]              la_data_out;
  logic [NUM_REGS*REG_W-1:0] regs;
  logic                      core_start;
  logic                      core_done;
  logic                      core_wr_en;
  logic [3:0]                core_wr_idx;
  logic [REG_W-1:0]          core_wr_data;

  int errors = 0;
  int checks = 0;
  logic tog_b;
  int exp_cnt;
  logic [NUM_REGS*REG_W-1:0] exp_regs;

  always #5 clk = ~clk;

  la_regbank_ctrl #(
    .REG_W   (REG_W),
    .NUM_REGS(NUM_REGS),
    .CHUNK_W (CHUNK_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .la_data_in    (la_data_in),
    .la_oenb       (la_oenb),
    .la_data_out   (la_data_out),
    .regs_o        (regs),
    .core_start_o  (core_start),
    .core_done_i   (core_done),
    .core_wr_en_i  (core_wr_en),
    .core_wr_idx_i (core_wr_idx),
    .core_wr_data_i(core_wr_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] r, input logic [3:0] c,
                      input logic [95:0] d);
    tog_b = ~tog_b;
    exp_cnt++;
    la_data_in = {d, op, r, c, 4'h0, tog_b, 15'h0};
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; la_data_in = '0; la_oenb = '0; core_done = 1'b0;
    core_wr_en = 1'b0; core_wr_idx = '0; core_wr_data = '0;
    tog_b = 1'b0; exp_cnt = 0; exp_regs = '0;
    tick(); tick();
    checks++; if (la_data_out !== 128'h0) begin
      errors++; $display("FAIL reset_out: got %h want 0", la_data_out); end
    checks++; if (regs !== exp_regs) begin
      errors++; $display("FAIL reset_regs: got %h want 0", regs); end
    checks++; if (core_start !== 1'b0) begin
      errors++; $display("FAIL reset_start: got %b want 0", core_start); end
    // A LOAD toggle raised right at release must wait for the two sync edges
    rst_n = 1'b1;
    tog_b = 1'b1; exp_cnt = 1;
    la_data_in = {96'h0, OP_LOAD, 4'h0, 4'h0, 4'h0, tog_b, 15'h0};
    tick();
    checks++; if (la_data_out[31:30] !== 2'd0) begin
      errors++; $display("FAIL sync_edge1: state %0d want 0", la_data_out[31:30]); end
    tick();
    checks++; if (la_data_out[31:30] !== 2'd0) begin
      errors++; $display("FAIL sync_edge2: state %0d want 0", la_data_out[31:30]); end
    tick();
    checks++; if (la_data_out[31:30] !== 2'd1) begin
      errors++; $display("FAIL sync_load: state %0d want 1", la_data_out[31:30]); end
    checks++; if (la_data_out[23:16] !== 8'(exp_cnt)) begin
      errors++; $display("FAIL sync_cnt: got %0d want %0d", la_data_out[23:16], exp_cnt); end
  endtask

  task automatic test_load_write();
    send(OP_WRITE, 4'h0, 4'h0, 96'h1);
    send(OP_WRITE, 4'h0, 4'h1, 96'h2);
    exp_regs[REG_W-1:0] = {81'h2, 82'h1};
    checks++; if (regs[REG_W-1:0] !== {81'h2, 82'h1}) begin
      errors++; $display("FAIL write_reg0: got %h want %h", regs[REG_W-1:0], {81'h2, 82'h1}); end
    // Top chunk is only 81 bits wide; extra data bits must be dropped
    send(OP_WRITE, 4'h3, 4'h1, {96{1'b1}});
    exp_regs[3*REG_W+82 +: 81] = '1;
    checks++; if (regs !== exp_regs) begin
      errors++; $display("FAIL write_trunc: got %h want %h", regs, exp_regs); end
    checks++; if (la_data_out[31:27] !== {2'd1, tog_b, 2'b00}) begin
      errors++; $display("FAIL write_status: got %b want %b", la_data_out[31:27],
                         {2'd1, tog_b, 2'b00}); end
    checks++; if (la_data_out[23:16] !== 8'(exp_cnt)) begin
      errors++; $display("FAIL write_cnt: got %0d want %0d", la_data_out[23:16], exp_cnt); end
  endtask

  task automatic test_no_toggle();
    la_data_in[127:32] = 96'hABCD_EF01_2345_6789_0000_FFFF;
    tick(); tick(); tick();
    checks++; if (regs !== exp_regs) begin
      errors++; $display("FAIL notog_regs: got %h want %h", regs, exp_regs); end
    checks++; if (la_data_out[28] !== 1'b0 || la_data_out[23:16] !== 8'(exp_cnt)) begin
      errors++; $display("FAIL notog_status: err %b cnt %0d want 0 %0d", la_data_out[28],
                         la_data_out[23:16], exp_cnt); end
  endtask

  task automatic test_bad_cmd();
    send(OP_WRITE, 4'h9, 4'h0, 96'hFF);
    checks++; if (la_data_out[28] !== 1'b1) begin
      errors++; $display("FAIL bad_reg_err: got %b want 1", la_data_out[28]); end
    checks++; if (regs !== exp_regs) begin
      errors++; $display("FAIL bad_reg_regs: got %h want %h", regs, exp_regs); end
    send(OP_WRITE, 4'h0, 4'h2, 96'hFF);
    checks++; if (regs !== exp_regs) begin
      errors++; $display("FAIL bad_chunk_regs: got %h want %h", regs, exp_regs); end
    send(OP_READ, 4'h0, 4'h0, 96'h0);
    checks++; if (la_data_out[31:30] !== 2'd1 || la_data_out[127:32] !== 96'h0) begin
      errors++; $display("FAIL bad_op: state %0d rd %h want 1 0", la_data_out[31:30],
                         la_data_out[127:32]); end
    checks++; if (la_data_out[23:16] !== 8'(exp_cnt)) begin
      errors++; $display("FAIL bad_cnt: got %0d want %0d", la_data_out[23:16], exp_cnt); end
  endtask

  task automatic test_writeback_outside();
    core_wr_en = 1'b1; core_wr_idx = 4'h5; core_wr_data = '1;
    tick();
    core_wr_en = 1'b0;
    checks++; if (regs !== exp_regs) begin
      errors++; $display("FAIL wb_outside: got %h want %h", regs, exp_regs); end
  endtask

  task automatic test_go_done();
    send(OP_GO, 4'h0, 4'h0, 96'h0);
    checks++; if (core_start !== 1'b1 || la_data_out[31:30] !== 2'd2) begin
      errors++; $display("FAIL go_start: start %b state %0d want 1 2", core_start,
                         la_data_out[31:30]); end
    core_wr_en = 1'b1; core_wr_idx = 4'h6; core_wr_data = '1;
    tick();
    core_wr_en = 1'b0;
    checks++; if (core_start !== 1'b0) begin
      errors++; $display("FAIL go_pulse: got %b want 0", core_start); end
    exp_regs[6*REG_W +: REG_W] = '1;
    checks++; if (regs !== exp_regs) begin
      errors++; $display("FAIL wb_proc: got %h want %h", regs, exp_regs); end
    repeat (DONE_CYC - 2) tick();
    checks++; if (la_data_out[31:30] !== 2'd2) begin
      errors++; $display("FAIL pre_done: state %0d want 2", la_data_out[31:30]); end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++; if (la_data_out[31:30] !== 2'd3 || la_data_out[27] !== 1'b0) begin
      errors++; $display("FAIL done_read: state %0d errto %b want 3 0", la_data_out[31:30],
                         la_data_out[27]); end
  endtask

  task automatic test_read();
    logic [95:0] exp_rd;
    exp_rd = '0;
    exp_rd[80:0] = '1;
    send(OP_READ, 4'h6, 4'h1, 96'h0);
    checks++; if (la_data_out[127:32] !== exp_rd) begin
      errors++; $display("FAIL read_r6c1: got %h want %h", la_data_out[127:32], exp_rd); end
    send(OP_READ, 4'h0, 4'h1, 96'h0);
    checks++; if (la_data_out[127:32] !== 96'h2) begin
      errors++; $display("FAIL read_r0c1: got %h want 2", la_data_out[127:32]); end
  endtask

  task automatic test_finish();
    send(OP_FINISH, 4'h0, 4'h0, 96'h0);
    checks++; if (la_data_out[31:29] !== {2'd0, tog_b} || la_data_out[23:16] !== 8'(exp_cnt))
    begin
      errors++; $display("FAIL finish: st %b cnt %0d want %b %0d", la_data_out[31:29],
                         la_data_out[23:16], {2'd0, tog_b}, exp_cnt); end
  endtask

  task automatic test_done_with_toggle();
    send(OP_LOAD, 4'h0, 4'h0, 96'h0);
    exp_regs = '0;
    checks++; if (regs !== exp_regs || la_data_out[28] !== 1'b0) begin
      errors++; $display("FAIL load_clear: err %b regs %h want 0", la_data_out[28], regs); end
    send(OP_GO, 4'h0, 4'h0, 96'h0);
    tick();
    core_done = 1'b1;
    send(OP_FINISH, 4'h0, 4'h0, 96'h0);
    core_done = 1'b0;
    checks++; if (la_data_out[31:30] !== 2'd3 || la_data_out[23:16] !== 8'(exp_cnt - 1)) begin
      errors++; $display("FAIL same_cyc_done: st %0d cnt %0d want 3 %0d", la_data_out[31:30],
                         la_data_out[23:16], exp_cnt - 1); end
    tick();
    checks++; if (la_data_out[31:30] !== 2'd0 || la_data_out[23:16] !== 8'(exp_cnt)) begin
      errors++; $display("FAIL same_cyc_cmd: st %0d cnt %0d want 0 %0d", la_data_out[31:30],
                         la_data_out[23:16], exp_cnt); end
  endtask

  task automatic test_timeout();
    send(OP_LOAD, 4'h0, 4'h0, 96'h0);
    send(OP_WRITE, 4'h1, 4'h0, 96'h5);
    exp_regs[REG_W +: REG_W] = 163'h5;
    send(OP_GO, 4'h0, 4'h0, 96'h0);
`ifdef LA_REGBANK_TIMEOUT_EN
    repeat (TIMEOUT - 1) tick();
    checks++; if (la_data_out[31:30] !== 2'd2) begin
      errors++; $display("FAIL to_before: state %0d want 2", la_data_out[31:30]); end
    tick();
    checks++; if (la_data_out[31:30] !== 2'd3 || la_data_out[27] !== 1'b1) begin
      errors++; $display("FAIL to_expire: st %0d errto %b want 3 1", la_data_out[31:30],
                         la_data_out[27]); end
`else
    repeat (100) tick();
    checks++; if (la_data_out[31:30] !== 2'd2 || la_data_out[27] !== 1'b0) begin
      errors++; $display("FAIL no_to: st %0d errto %b want 2 0", la_data_out[31:30],
                         la_data_out[27]); end
`endif
    send(OP_ABORT, 4'h0, 4'h0, 96'h0);
    checks++; if (la_data_out[31:30] !== 2'd0 || regs !== exp_regs) begin
      errors++; $display("FAIL abort: st %0d regs %h want 0 %h", la_data_out[31:30], regs,
                         exp_regs); end
  endtask

  task automatic test_reset_mid();
    send(OP_LOAD, 4'h0, 4'h0, 96'h0);
    send(OP_WRITE, 4'h2, 4'h0, 96'h7);
    send(OP_GO, 4'h0, 4'h0, 96'h0);
    tick();
    rst_n = 1'b0;
    #2;
    checks++; if (la_data_out !== 128'h0 || regs !== '0 || core_start !== 1'b0) begin
      errors++; $display("FAIL reset_mid: out %h start %b want 0 0", la_data_out, core_start);
    end
    la_data_in = '0; tog_b = 1'b0; exp_cnt = 0; exp_regs = '0;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (la_data_out !== 128'h0 || regs !== exp_regs) begin
      errors++; $display("FAIL post_reset: out %h want 0", la_data_out); end
  endtask

  initial begin
    test_reset();
    test_load_write();
    test_no_toggle();
    test_bad_cmd();
    test_writeback_outside();
    test_go_done();
    test_read();
    test_finish();
    test_done_with_toggle();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/la_regbank_ctrl.md
LA_REGBANK_CTRL -- requirements
Module: la_regbank_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 163, meaning operand register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 7, meaning operand register count (max 16).
REQ-003 SHALL have parameter CHUNK_W, default 82, meaning LA data bits per transfer (max 96).
REQ-004 SHALL have parameter TIMEOUT, default 2000, meaning the PROC watchdog limit in cycles.
REQ-005 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port wb_rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port la_data_in, input, 128 bits: [127:32] data, [31:16] command, [15] toggle.
REQ-008 SHALL have port la_oenb, input, 128 bits: a command bit is honoured only where its oenb bit is 0.
REQ-009 SHALL have port la_data_out, output, 128 bits: [127:32] read data, [31:16] status.
REQ-010 SHALL have port regs_o, output, NUM_REGS*REG_W bits: flat register file, reg k at [k*REG_W +: REG_W].
REQ-011 SHALL have port core_start_o, output, 1 bit: one-cycle start pulse.
REQ-012 SHALL have port core_done_i, input, 1 bit: core completion.
REQ-013 SHALL have ports core_wr_en_i (1), core_wr_idx_i (4) and core_wr_data_i (REG_W), inputs: result write-back.

Function
REQ-014 SHALL define NCH = ceil(REG_W/CHUNK_W); chunk c SHALL map to bits [c*CHUNK_W +: CHUNK_W], truncated at REG_W-1.
REQ-015 SHALL execute a command only on a change of la_data_in[15] versus its registered copy; exactly one execution per toggle.
REQ-016 SHALL decode command fields: [31:28] opcode, [27:24] reg index, [23:20] chunk index.
REQ-017 SHALL implement opcodes 1 LOAD, 2 WRITE, 3 GO, 4 READ, 5 FINISH and F ABORT.
REQ-018 SHALL implement states IDLE, LOAD, PROC and READ, with these transitions:
- IDLE--LOAD-->LOAD, clearing all registers
- LOAD--GO-->PROC, with core_start_o high exactly one cycle
- PROC--core_done_i-->READ
- READ--FINISH-->IDLE
- any--ABORT-->IDLE, registers retained
REQ-019 SHALL, on WRITE in LOAD, store la_data_in[32 +: CHUNK_W] into the addressed chunk on the next edge.
REQ-020 SHALL, on READ in READ, present the addressed chunk zero-extended on la_data_out[127:32] the next cycle.
REQ-021 SHALL reject, with status bit ERR_CMD and no state change, any opcode illegal in the current state, reg index >= NUM_REGS, or chunk index >= NCH.
REQ-022 SHALL, in PROC only, write core_wr_data_i to register core_wr_idx_i when core_wr_en_i is high; write-back outside PROC SHALL be ignored.
REQ-023 SHALL, when core_done_i and a toggle arrive in the same cycle in PROC, take done first and evaluate the command in READ.
REQ-024 SHALL drive status fields:
- [31:30] state
- [29] toggle echo, updated once the command completes
- [28] ERR_CMD, sticky
- [27] ERR_TO, sticky
- [23:16] the 8-bit count of processed commands, wrapping 255->0
REQ-025 SHALL clear ERR_CMD and ERR_TO on LOAD.

Reset
REQ-026 SHALL, while wb_rst_n_i is low, force state to IDLE and clear regs_o, la_data_out, core_start_o, the registered toggle, the counters and the error bits.
REQ-027 SHALL, on reset asserted mid-operation, abandon the operation; deassertion SHALL be synchronised so the first active edge follows two clean cycles.

Configuration
REQ-028 SHALL, with LA_REGBANK_TIMEOUT_EN defined, count cycles in PROC and, at TIMEOUT with no core_done_i, set ERR_TO and enter READ.
REQ-029 SHALL, without LA_REGBANK_TIMEOUT_EN, wait in PROC indefinitely, keep ERR_TO at 0 and contain no watchdog counter logic.

Structure
REQ-030 SHALL place the opcode constants, state encoding and status bit positions in package la_regbank_pkg.
REQ-031 SHALL place the watchdog in sub-module la_proc_timer (enable, clear, expired), instantiated only under LA_REGBANK_TIMEOUT_EN.

Verification
REQ-032 SHALL cover: LOAD, WRITE reg0 chunk0 = 82'h1, WRITE reg0 chunk1 = 81'h2 -> regs_o[162:0] = {81'h2, 82'h1}.
REQ-033 SHALL cover: GO -> core_start_o high exactly 1 cycle; core_done_i at cycle 50 -> status state = READ.
REQ-034 SHALL cover: READ reg6 chunk1 after write-back of all-ones -> la_data_out[112:32] all ones, [127:113] zero.
REQ-035 SHALL cover: WRITE with reg index 9, or command repeated without toggle -> ERR_CMD = 1 (first case only) and registers unchanged.
REQ-036 SHALL cover, with TIMEOUT=20 and the macro defined: GO with no done -> READ entered on cycle 20 with ERR_TO = 1; without the macro -> still PROC at cycle 100.
REQ-037 SHALL cover: reset pulse during PROC -> state IDLE, regs_o = 0, status = 0.
